// File: rtl/col_seq_ctrl_if.sv
// Configuration, control and status bundle for one column sequencer.
// The master drives the config stream and run control; the slave is col_seq_ctrl.
interface col_seq_ctrl_if #(
    parameter int RUN_W  = 16,
    parameter int WORD_W = 32
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;
    logic              start;
    logic              abort;
    logic [RUN_W-1:0]  run_len;
    logic [31:0]       CONF_ALU;
    logic [23:0]       CONF_SEL_A;
    logic [23:0]       CONF_SEL_B;
    logic [79:0]       CONF_SE;
    logic [6:0]        CONF_SEL_DR;
    logic              armed;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cfg_valid, cfg_data, start, abort, run_len,
        input  cfg_ready, CONF_ALU, CONF_SEL_A, CONF_SEL_B, CONF_SE, CONF_SEL_DR,
        input  armed, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_data, start, abort, run_len,
        output cfg_ready, CONF_ALU, CONF_SEL_A, CONF_SEL_B, CONF_SE, CONF_SEL_DR,
        output armed, busy, done, err
    );
endinterface

// File: rtl/col_seq_ctrl.sv
// Column config loader (6-word stream, atomic commit) and door-register
// wavefront sequencer: skewed turn-on, hold for run_len cycles, skewed turn-off.
module col_seq_ctrl #(
    parameter int RUN_W  = 16,
    parameter int WORD_W = 32
) (
    input logic            CLK,
    input logic            RST,
    col_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, WAVE_ON, RUN, WAVE_OFF} state_t;

    state_t            state_q, state_d;
    logic [2:0]        word_cnt_q, word_cnt_d;
    logic [2:0]        step_q, step_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;

    logic [WORD_W-1:0] sh_alu_q, sh_alu_d;
    logic [23:0]       sh_sel_a_q, sh_sel_a_d;
    logic [23:0]       sh_sel_b_q, sh_sel_b_d;
    logic [WORD_W-1:0] sh_se_lo_q, sh_se_lo_d;
    logic [WORD_W-1:0] sh_se_mid_q, sh_se_mid_d;

    logic [31:0]       conf_alu_q, conf_alu_d;
    logic [23:0]       conf_sel_a_q, conf_sel_a_d;
    logic [23:0]       conf_sel_b_q, conf_sel_b_d;
    logic [79:0]       conf_se_q, conf_se_d;
    logic [6:0]        mask_q, mask_d;
    logic              committed_q, committed_d;

    logic [6:0]        dr_q, dr_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              cfg_ready;
    logic              cfg_fire;
    logic              in_run;

    // A start in ARMED claims the cycle, so a coincident config word is refused.
    assign cfg_ready = (state_q == IDLE) || (state_q == LOAD) ||
                       ((state_q == ARMED) && !bus.start);
    assign cfg_fire  = bus.cfg_valid && cfg_ready;
    assign in_run    = (state_q == WAVE_ON) || (state_q == RUN) || (state_q == WAVE_OFF);

    always_comb begin
        // NOTE: every variable gets its default first so no path can infer a latch.
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        step_d       = step_q;
        run_cnt_d    = run_cnt_q;
        sh_alu_d     = sh_alu_q;
        sh_sel_a_d   = sh_sel_a_q;
        sh_sel_b_d   = sh_sel_b_q;
        sh_se_lo_d   = sh_se_lo_q;
        sh_se_mid_d  = sh_se_mid_q;
        conf_alu_d   = conf_alu_q;
        conf_sel_a_d = conf_sel_a_q;
        conf_sel_b_d = conf_sel_b_q;
        conf_se_d    = conf_se_q;
        mask_d       = mask_q;
        committed_d  = committed_q;
        dr_d         = dr_q;
        armed_d      = armed_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        if (in_run && bus.abort) begin
            dr_d    = '0;
            busy_d  = 1'b0;
            armed_d = 1'b1;
            step_d  = '0;
            state_d = ARMED;
        end else begin
            case (state_q)
                IDLE, LOAD, ARMED: begin
                    if ((state_q == LOAD) && bus.abort) begin
                        word_cnt_d = '0;
                        armed_d    = committed_q;
                        state_d    = committed_q ? ARMED : IDLE;
                    end else if ((state_q == ARMED) && bus.start && !bus.abort) begin
                        run_cnt_d = bus.run_len;
                        step_d    = '0;
                        state_d   = WAVE_ON;
                    end else begin
                        err_d = bus.start && !bus.abort && (state_q != ARMED);
                        if (cfg_fire) begin
                            case (word_cnt_q)
                                3'd0:    sh_alu_d    = bus.cfg_data;
                                3'd1:    sh_sel_a_d  = bus.cfg_data[23:0];
                                3'd2:    sh_sel_b_d  = bus.cfg_data[23:0];
                                3'd3:    sh_se_lo_d  = bus.cfg_data;
                                3'd4:    sh_se_mid_d = bus.cfg_data;
                                default: begin
                                    conf_alu_d   = sh_alu_q;
                                    conf_sel_a_d = sh_sel_a_q;
                                    conf_sel_b_d = sh_sel_b_q;
                                    conf_se_d    = {bus.cfg_data[15:0], sh_se_mid_q, sh_se_lo_q};
                                    mask_d       = bus.cfg_data[22:16];
                                    committed_d  = 1'b1;
                                end
                            endcase
                            if (word_cnt_q == 3'd5) begin
                                word_cnt_d = '0;
                                armed_d    = 1'b1;
                                state_d    = ARMED;
                            end else begin
                                word_cnt_d = word_cnt_q + 3'd1;
                                armed_d    = 1'b0;
                                state_d    = LOAD;
                            end
                        end
                    end
                end

                // One boundary per cycle; masked boundaries simply never rise.
                WAVE_ON: begin
                    dr_d[step_q] = mask_q[step_q];
                    busy_d       = 1'b1;
                    armed_d      = 1'b0;
                    if (step_q == 3'd6) begin
                        step_d  = '0;
                        state_d = (run_cnt_q == '0) ? WAVE_OFF : RUN;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end

                RUN: begin
                    run_cnt_d = run_cnt_q - RUN_W'(1);
                    if (run_cnt_q == RUN_W'(1)) begin
                        step_d  = '0;
                        state_d = WAVE_OFF;
                    end
                end

                WAVE_OFF: begin
                    dr_d[step_q] = 1'b0;
                    if (step_q == 3'd6) begin
                        step_d  = '0;
                        busy_d  = 1'b0;
                        armed_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ARMED;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments only; reset also clears the shadow
    // and committed registers because a reset must leave no stale configuration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            step_q       <= '0;
            run_cnt_q    <= '0;
            sh_alu_q     <= '0;
            sh_sel_a_q   <= '0;
            sh_sel_b_q   <= '0;
            sh_se_lo_q   <= '0;
            sh_se_mid_q  <= '0;
            conf_alu_q   <= '0;
            conf_sel_a_q <= '0;
            conf_sel_b_q <= '0;
            conf_se_q    <= '0;
            mask_q       <= '0;
            committed_q  <= 1'b0;
            dr_q         <= '0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            step_q       <= step_d;
            run_cnt_q    <= run_cnt_d;
            sh_alu_q     <= sh_alu_d;
            sh_sel_a_q   <= sh_sel_a_d;
            sh_sel_b_q   <= sh_sel_b_d;
            sh_se_lo_q   <= sh_se_lo_d;
            sh_se_mid_q  <= sh_se_mid_d;
            conf_alu_q   <= conf_alu_d;
            conf_sel_a_q <= conf_sel_a_d;
            conf_sel_b_q <= conf_sel_b_d;
            conf_se_q    <= conf_se_d;
            mask_q       <= mask_d;
            committed_q  <= committed_d;
            dr_q         <= dr_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.cfg_ready   = cfg_ready;
    assign bus.CONF_ALU    = conf_alu_q;
    assign bus.CONF_SEL_A  = conf_sel_a_q;
    assign bus.CONF_SEL_B  = conf_sel_b_q;
    assign bus.CONF_SE     = conf_se_q;
    assign bus.CONF_SEL_DR = dr_q;
    assign bus.armed       = armed_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_col_seq_ctrl.sv
// Scoreboard bench for col_seq_ctrl: expected wavefront traces are derived from
// the start/hold/abort timing and queued when a run is launched.
module tb_col_seq_ctrl;

    localparam int RUN_W = 16;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    col_seq_ctrl_if #(.RUN_W(RUN_W), .WORD_W(32)) bus ();

    col_seq_ctrl #(.RUN_W(RUN_W), .WORD_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [6:0] dr;
        logic       busy;
        logic       armed;
        logic       done;
        logic       err;
    } obs_t;

    obs_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_alu   = '0;
    logic [23:0] exp_sel_a = '0;
    logic [23:0] exp_sel_b = '0;
    logic [79:0] exp_se    = '0;

    logic [31:0] cfg1 [6] = '{32'h7654_3210, 32'h00FA_C688, 32'h0012_3456,
                              32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h007F_03FF};
    logic [31:0] cfg2 [6] = '{32'h89AB_CDEF, 32'h00A5_A5A5, 32'h005A_5A5A,
                              32'h0123_4567, 32'hCAFE_F00D, 32'h0055_0155};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t s;
        s = {bus.CONF_SEL_DR, bus.busy, bus.armed, bus.done, bus.err};
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_conf(input string tag);
        check({tag, " alu"},   bus.CONF_ALU,   exp_alu);
        check({tag, " sel_a"}, bus.CONF_SEL_A, exp_sel_a);
        check({tag, " sel_b"}, bus.CONF_SEL_B, exp_sel_b);
        check({tag, " se"},    bus.CONF_SE,    exp_se);
    endtask

    task automatic drive_word(input logic [31:0] w);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = w;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    // Full six-word load; gap_mask bit k inserts an idle cycle before word k.
    task automatic load_cfg(input logic [31:0] w [6], input logic [5:0] gap_mask);
        for (int k = 0; k < 6; k++) begin
            if (gap_mask[k]) begin
                tick();
                if (k > 0) check($sformatf("gap%0d armed", k), bus.armed, 1'b0);
            end
            check($sformatf("w%0d ready", k), bus.cfg_ready, 1'b1);
            drive_word(w[k]);
            if (k < 5) begin
                check($sformatf("w%0d armed", k), bus.armed, 1'b0);
                check_conf($sformatf("w%0d hold", k));
            end else begin
                exp_alu   = w[0];
                exp_sel_a = w[1][23:0];
                exp_sel_b = w[2][23:0];
                exp_se    = {w[5][15:0], w[4], w[3]};
                check("commit armed", bus.armed, 1'b1);
                check("commit busy", bus.busy, 1'b0);
                check_conf("commit");
            end
        end
    endtask

    // Launch a run and compare every cycle against the queued trace.
    // abort_e / start_e: edge (relative to the start edge) at which abort / a
    // stray start is sampled; 0 disables.
    task automatic run_wave(input logic [6:0] mask, input int r, input int abort_e,
                            input int start_e);
        int   tt;
        int   last;
        int   e;
        obs_t x;
        tt   = 7 + r;
        last = (abort_e > 0) ? abort_e + 2 : tt + 8;
        for (int k = 0; k <= last; k++) begin
            x.err = 1'b0;
            if (abort_e > 0 && k >= abort_e) begin
                x.dr = '0; x.busy = 1'b0; x.armed = 1'b1; x.done = 1'b0;
            end else begin
                for (int i = 0; i < 7; i++)
                    x.dr[i] = mask[i] && (k >= 1 + i) && (k <= tt + i);
                x.busy  = (k >= 1) && (k <= tt + 6);
                x.armed = (k == 0) || (k >= tt + 7);
                x.done  = (k == tt + 7);
            end
            exp_q.push_back(x);
        end

        bus.start     = 1'b1;
        bus.run_len   = RUN_W'(r);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 32'hFFFF_FFFF;
        #1;
        check($sformatf("m%0h r%0d ready gated", mask, r), bus.cfg_ready, 1'b0);
        tick();
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;

        e = 0;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check($sformatf("run m%0h r%0d e%0d", mask, r, e), sample(), x);
            e++;
            if (exp_q.size() != 0) begin
                bus.abort = (e == abort_e);
                bus.start = (e == start_e);
                tick();
                bus.abort = 1'b0;
                bus.start = 1'b0;
            end
        end
        check_conf($sformatf("m%0h r%0d after", mask, r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.run_len   = '0;
        RST           = 1'b1;

        tick();
        tick();
        check("rst dr", bus.CONF_SEL_DR, 7'h00);
        check("rst flags", {bus.armed, bus.busy, bus.done, bus.err}, 4'b0000);
        check_conf("rst");
        RST = 1'b0;
        tick();
        check("idle ready", bus.cfg_ready, 1'b1);
        check("idle armed", bus.armed, 1'b0);

        // start in IDLE: err pulse only
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("idle start err", bus.err, 1'b1);
        check("idle start dr", bus.CONF_SEL_DR, 7'h00);
        tick();
        check("idle err pulse", bus.err, 1'b0);
        check("idle busy", bus.busy, 1'b0);

        load_cfg(cfg1, 6'b010110);
        check("cfg1 se literal", bus.CONF_SE, 80'h03FF_0BADF00D_DEADBEEF);

        run_wave(7'h7F, 3, 0, 4);

        load_cfg(cfg2, 6'b000000);
        run_wave(7'h55, 0, 0, 0);
        run_wave(7'h55, 5, 10, 0);
        run_wave(7'h55, 2, 0, 0);

        // partial reload, start in LOAD, then abort: old config kept
        drive_word(cfg1[0]);
        check("partial armed", bus.armed, 1'b0);
        drive_word(cfg1[1]);
        drive_word(cfg1[2]);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("load start err", bus.err, 1'b1);
        check("load start dr", bus.CONF_SEL_DR, 7'h00);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort load armed", bus.armed, 1'b1);
        check("abort load err", bus.err, 1'b0);
        check_conf("abort load");
        run_wave(7'h55, 1, 0, 0);

        // reset while all enables are up
        load_cfg(cfg1, 6'b100001);
        bus.start   = 1'b1;
        bus.run_len = RUN_W'(3);
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("pre-rst dr", bus.CONF_SEL_DR, 7'h7F);
        check("pre-rst busy", bus.busy, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        exp_alu = '0; exp_sel_a = '0; exp_sel_b = '0; exp_se = '0;
        check("async rst dr", bus.CONF_SEL_DR, 7'h00);
        check("async rst flags", {bus.armed, bus.busy, bus.done, bus.err}, 4'b0000);
        check_conf("async rst");
        tick();
        RST = 1'b0;
        tick();
        check("post-rst ready", bus.cfg_ready, 1'b1);
        check("post-rst armed", bus.armed, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("post-rst start err", bus.err, 1'b1);
        check("post-rst dr", bus.CONF_SEL_DR, 7'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/col_seq_ctrl.md
Name: col_seq_ctrl

Overview:
Configuration loader and execution sequencer for one 8-PE column. Accepts a 6-word configuration stream into shadow registers and commits it atomically to the column's CONF_ALU/CONF_SEL_A/CONF_SEL_B/CONF_SE buses. On start, it drives the seven inter-PE door-register enables (boundaries 01..67) as a skewed wavefront: on, hold for a run length, off. It sits beside the column instance in the array top; the clocks clk_01..clk_67 are not gated here.

Parameters:
RUN_W, 16, width of run-length input and internal run counter
WORD_W, 32, configuration stream word width (fixed; other values unsupported)

Ports:
CLK  in  1  single clock
RST  in  1  asynchronous, active-high reset
cfg_valid  in  1  config word valid
cfg_ready  out  1  config word accepted when cfg_valid&cfg_ready
cfg_data  in  32  config word
start  in  1  single-cycle run request
abort  in  1  single-cycle abort request
run_len  in  RUN_W  hold cycles, sampled on accepted start
CONF_ALU  out  32  committed ALU config, 4 bits/PE
CONF_SEL_A  out  24  committed A-select, 3 bits/PE
CONF_SEL_B  out  24  committed B-select, 3 bits/PE
CONF_SE  out  80  committed SE config, 10 bits/PE
CONF_SEL_DR  out  7  door-register enables, bit i = boundary i→i+1
armed  out  1  valid committed config present, idle
busy  out  1  wavefront in progress
done  out  1  one-cycle pulse at run completion
err  out  1  one-cycle pulse on illegal start

Behaviour:
- Reset: all outputs 0, state IDLE, word count 0, mask 0, shadow registers 0.
- Word map: w0→ALU[31:0]; w1[23:0]→SEL_A; w2[23:0]→SEL_B; w3→SE[31:0]; w4→SE[63:32]; w5[15:0]→SE[79:64]; w5[22:16]→stage mask. Unused bits ignored.
- States: IDLE, LOAD, ARMED, WAVE_ON, RUN, WAVE_OFF.
- cfg_ready=1 in IDLE, LOAD, ARMED; 0 otherwise. The first accepted word moves the block to LOAD; armed drops, but committed CONF_* outputs keep their old values.
- On the edge accepting w5, all CONF_* outputs and the mask update together. The next state is ARMED, with armed=1 from that edge.
- start in ARMED, sampled at edge t: run_len is latched, busy=1 and armed=0 from t+1.
- WAVE_ON: CONF_SEL_DR[i] rises at edge t+1+i, gated by mask[i]. Masked bits stay 0 throughout. The block leaves WAVE_ON after edge t+7.
- RUN: holds for R=run_len cycles. R=0 skips RUN. T = t+7+R.
- WAVE_OFF: CONF_SEL_DR[i] falls at edge T+1+i. Each enabled bit is high for exactly 7+R cycles.
- At edge T+7: done=1 for one cycle, busy=0, state ARMED, armed=1. The config is retained, so start may repeat.
- start in IDLE or LOAD: ignored, err=1 next cycle. start while busy: ignored, no err.
- abort while busy: all CONF_SEL_DR cleared at the next edge, busy=0, state ARMED, no done.
- abort in LOAD: partial words discarded, count=0, shadow unchanged in effect. State returns to ARMED if a prior commit exists, else IDLE.
- abort in IDLE or ARMED: no effect.
- abort and start in the same cycle: abort wins.
- cfg_valid and start in the same ARMED cycle: start wins, and the word is not accepted (cfg_ready is combinationally 0 when start=1 in ARMED).
- RST mid-run: all enables drop immediately (asynchronously) and the committed config is cleared.

Test Plan:
- Load w0=0x76543210, w1=0x00FAC688, w2=0x00123456, w3=0xDEADBEEF, w4=0x0BADF00D, w5=0x007F03FF -> CONF_ALU=0x76543210, CONF_SE=0x3FF_0BADF00D_DEADBEEF, armed=1 on the w5 edge; outputs unchanged before w5. Insert cfg_valid gaps; the count must hold.
- Mask 0x7F, start at t with run_len=3 -> CONF_SEL_DR[i] high edges t+1+i..t+10+i, busy t+1..t+16, done pulse at t+17, then armed=1.
- Mask 0x55, run_len=0 -> only bits 0,2,4,6 toggle, each high 7 cycles; bits 1,3,5 stay 0; done at t+14.
- abort at t+9 of a run_len=5 run -> CONF_SEL_DR=0 at t+10, no done, armed=1; a restart then behaves as a fresh run.
- start in IDLE after reset -> err pulse, no enables. Reload config while ARMED, then abort at word 3 -> old CONF_* retained, armed=1.
- Assert RST while busy with CONF_SEL_DR=0x7F -> all outputs 0 before the next edge, state IDLE.
